// File: rtl/calc_nport_pkg.sv
// calc_nport_pkg: shared definitions for the multi-port calculator.
//   Command and response codes, field widths, capture FSM states and the
//   queued request entry. Operand fields are sized for the widest supported
//   DATA_W (64). Narrower instances zero-extend into them and use only the
//   low DATA_W bits.
package calc_nport_pkg;

   localparam int CMD_W      = 4;
   localparam int RESP_W     = 2;
   localparam int MAX_DATA_W = 64;

   localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
   localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
   localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
   localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
   localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

   localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
   localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
   localparam logic [RESP_W-1:0] RESP_OVF  = 2'd2;
   localparam logic [RESP_W-1:0] RESP_INV  = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OP2  = 1'b1
   } cap_state_e;

   typedef struct packed {
      logic [CMD_W-1:0]      cmd;
      logic [MAX_DATA_W-1:0] op1;
      logic [MAX_DATA_W-1:0] op2;
   } fifo_entry_t;

endpackage

// File: rtl/calc_port_queue.sv
// calc_port_queue: one requester port of calc_nport.
//   Two-cycle capture FSM (cmd+op1, then op2) feeding a DEPTH-entry FIFO.
//   ready is only offered when the FSM is idle and a FIFO slot is free, so
//   the op2 push can never overflow: the count can only fall while in OP2.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   ST_IDLE | waiting for a nonzero cmd while ready is high
//   ST_OP2  | cmd/op1 held; this cycle's data is op2, push entry
//
// Ports:
//   clk_sys    in   clock, rising edge
//   rst_b      in   asynchronous active-low reset
//   cmd        in   CMD_W   command for this port
//   data       in   DATA_W  operand for this port
//   pop        in   1       remove the head entry (ignored when empty)
//   ready      out  1       port may start a new request this cycle
//   not_empty  out  1       FIFO holds at least one entry
//   head       out  entry   oldest queued entry
module calc_port_queue
   import calc_nport_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk_sys,
   input  logic              rst_b,
   input  logic [CMD_W-1:0]  cmd,
   input  logic [DATA_W-1:0] data,
   input  logic              pop,
   output logic              ready,
   output logic              not_empty,
   output fifo_entry_t       head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   cap_state_e        state_q, state_d;
   logic              live_q;
   logic [CMD_W-1:0]  cmd_q;
   logic [DATA_W-1:0] op1_q;
   logic              capture;
   logic              push;
   logic              pop_ok;
   fifo_entry_t       push_entry;
   fifo_entry_t       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;

   // live_q holds ready low through reset and raises it on the first edge after release.
   assign ready     = live_q && (state_q == ST_IDLE) && (count_q < CNT_W'(DEPTH));
   assign capture   = ready && (cmd != CMD_NOP);
   assign not_empty = (count_q != '0);
   assign pop_ok    = pop && not_empty;
   assign head      = mem[rd_ptr_q];

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= ST_IDLE;
         live_q  <= 1'b0;
         cmd_q   <= '0;
         op1_q   <= '0;
      end else begin
         state_q <= state_d;
         live_q  <= 1'b1;
         if (capture) begin
            cmd_q <= cmd;
            op1_q <= data;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      push       = 1'b0;
      push_entry = '0;
      case (state_q)
         ST_IDLE: begin
            if (capture) state_d = ST_OP2;
         end
         ST_OP2: begin
            push                       = 1'b1;
            push_entry.cmd             = cmd_q;
            push_entry.op1[DATA_W-1:0] = op1_q;
            push_entry.op2[DATA_W-1:0] = data;
            state_d                    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (push) mem[wr_ptr_q] <= push_entry;
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/calc_nport.sv
// calc_nport: NUM_PORTS requesters sharing one ALU/shifter.
//   Each port queues two-cycle requests in its own calc_port_queue. A
//   round-robin arbiter pops at most one entry per cycle. The result is
//   registered into the granted port's response slot for exactly one cycle.
//
// Ports:
//   c_clk        in   1                  clock, rising edge
//   reset        in   1                  asynchronous active-low reset
//   req_cmd_in   in   NUM_PORTS*4        per-port command (slice p)
//   req_data_in  in   NUM_PORTS*DATA_W   per-port operand
//   req_ready    out  NUM_PORTS          port may start a new request
//   out_resp     out  NUM_PORTS*2        per-port response code pulse
//   out_data     out  NUM_PORTS*DATA_W   per-port result pulse
module calc_nport
   import calc_nport_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 4
) (
   input  logic                        c_clk,
   input  logic                        reset,
   input  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in,
   input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
   output logic [NUM_PORTS-1:0]        req_ready,
   output logic [NUM_PORTS*RESP_W-1:0] out_resp,
   output logic [NUM_PORTS*DATA_W-1:0] out_data
);

   localparam int PORT_W  = $clog2(NUM_PORTS);
   localparam int SHAMT_W = $clog2(DATA_W);

   logic [NUM_PORTS-1:0]        not_empty;
   logic [NUM_PORTS-1:0]        pop;
   fifo_entry_t                 head [NUM_PORTS];
   logic [PORT_W-1:0]           ptr_q;
   logic [PORT_W-1:0]           grant_idx;
   logic                        grant_vld;
   fifo_entry_t                 sel;
   logic [DATA_W-1:0]           op1, op2;
   logic [DATA_W:0]             sum;
   logic [RESP_W-1:0]           alu_resp;
   logic [DATA_W-1:0]           alu_data;
   logic [NUM_PORTS*RESP_W-1:0] resp_d;
   logic [NUM_PORTS*DATA_W-1:0] data_d;
   logic                        unused_sel_hi;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      calc_port_queue #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_queue (
         .clk_sys   (c_clk),
         .rst_b     (reset),
         .cmd       (req_cmd_in[p*CMD_W +: CMD_W]),
         .data      (req_data_in[p*DATA_W +: DATA_W]),
         .pop       (pop[p]),
         .ready     (req_ready[p]),
         .not_empty (not_empty[p]),
         .head      (head[p])
      );
   end

   // Round robin: lowest non-empty port at or above ptr_q, else wrap to the lowest non-empty port.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      pop       = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!grant_vld && not_empty[i] && (PORT_W'(i) >= ptr_q)) begin
            grant_vld = 1'b1;
            grant_idx = PORT_W'(i);
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!grant_vld && not_empty[i]) begin
            grant_vld = 1'b1;
            grant_idx = PORT_W'(i);
         end
      end
      if (grant_vld) pop[grant_idx] = 1'b1;
   end

   assign sel = head[grant_idx];
   assign op1 = sel.op1[DATA_W-1:0];
   assign op2 = sel.op2[DATA_W-1:0];
   // Upper operand bits are always zero for DATA_W below the package maximum.
   assign unused_sel_hi = ^{sel.op1, sel.op2};

   always_comb begin
      alu_resp = RESP_NONE;
      alu_data = '0;
      sum      = '0;
      case (sel.cmd)
         CMD_ADD: begin
            sum = {1'b0, op1} + {1'b0, op2};
            if (sum[DATA_W]) begin
               alu_resp = RESP_OVF;
            end else begin
               alu_resp = RESP_OK;
               alu_data = sum[DATA_W-1:0];
            end
         end
         CMD_SUB: begin
            if (op1 < op2) begin
               alu_resp = RESP_OVF;
            end else begin
               alu_resp = RESP_OK;
               alu_data = op1 - op2;
            end
         end
         CMD_SHL: begin
            alu_resp = RESP_OK;
            alu_data = op1 << op2[SHAMT_W-1:0];
         end
         CMD_SHR: begin
            alu_resp = RESP_OK;
            alu_data = op1 >> op2[SHAMT_W-1:0];
         end
         default: alu_resp = RESP_INV;
      endcase
   end

   always_comb begin
      resp_d = '0;
      data_d = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant_vld && (grant_idx == PORT_W'(p))) begin
            resp_d[p*RESP_W +: RESP_W] = alu_resp;
            data_d[p*DATA_W +: DATA_W] = alu_data;
         end
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         ptr_q    <= '0;
         out_resp <= '0;
         out_data <= '0;
      end else begin
         out_resp <= resp_d;
         out_data <= data_d;
         if (grant_vld) begin
            ptr_q <= (grant_idx == PORT_W'(NUM_PORTS-1)) ? '0 : grant_idx + PORT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_calc_nport.sv
// tb_calc_nport: directed and random checks of calc_nport against a
// queue-based reference model.
module tb_calc_nport;
   import calc_nport_pkg::*;

   localparam int N = 4;
   localparam int W = 32;
   localparam int D = 4;

   logic             c_clk = 1'b0;
   logic             reset;
   logic [N*4-1:0]   req_cmd_in;
   logic [N*W-1:0]   req_data_in;
   logic [N-1:0]     req_ready;
   logic [N*2-1:0]   out_resp;
   logic [N*W-1:0]   out_data;

   logic [3:0]       cmd_drv  [N];
   logic [W-1:0]     data_drv [N];

   always #5 c_clk = ~c_clk;

   for (genvar p = 0; p < N; p++) begin : g_drv
      assign req_cmd_in[p*4 +: 4]  = cmd_drv[p];
      assign req_data_in[p*W +: W] = data_drv[p];
   end

   calc_nport #(.NUM_PORTS(N), .DATA_W(W), .DEPTH(D)) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .req_ready   (req_ready),
      .out_resp    (out_resp),
      .out_data    (out_data)
   );

   typedef struct packed {
      logic [1:0]   resp;
      logic [W-1:0] data;
   } res_t;

   res_t         q [N][$];
   int           phase [N];
   logic [3:0]   lcmd  [N];
   logic [W-1:0] lop1  [N];
   bit           en;
   int           ptr;
   logic [1:0]   exp_resp [N];
   logic [W-1:0] exp_data [N];
   int           n_assert, n_fail, issued, seen_resp;

   function automatic res_t ref_op(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
      res_t r;
      longint unsigned la, lb, lim;
      la = a; lb = b; lim = (64'd1 << W) - 1;
      r.resp = 2'd1;
      r.data = '0;
      case (c)
         4'd1: if (la + lb > lim) r.resp = 2'd2; else r.data = W'(la + lb);
         4'd2: if (la < lb) r.resp = 2'd2; else r.data = W'(la - lb);
         4'd5: r.data = W'(la << (lb % W));
         4'd6: r.data = W'(la >> (lb % W));
         default: r.resp = 2'd3;
      endcase
      return r;
   endfunction

   function automatic bit model_ready(int p);
      return en && (phase[p] == 0) && (q[p].size() < D);
   endfunction

   task automatic model_reset();
      for (int p = 0; p < N; p++) begin
         q[p].delete();
         phase[p]    = 0;
         exp_resp[p] = '0;
         exp_data[p] = '0;
      end
      en  = 1'b0;
      ptr = 0;
   endtask

   // Advance the model across one rising edge using the inputs held before it.
   task automatic model_step();
      bit   rdy [N];
      int   g;
      res_t r;
      for (int p = 0; p < N; p++) rdy[p] = model_ready(p);
      g = -1;
      for (int i = 0; i < N; i++)
         if (g < 0 && q[(ptr + i) % N].size() > 0) g = (ptr + i) % N;
      for (int p = 0; p < N; p++) begin
         exp_resp[p] = '0;
         exp_data[p] = '0;
      end
      if (g >= 0) begin
         r = q[g].pop_front();
         exp_resp[g] = r.resp;
         exp_data[g] = r.data;
         ptr = (g + 1) % N;
      end
      for (int p = 0; p < N; p++) begin
         if (phase[p] == 1) begin
            q[p].push_back(ref_op(lcmd[p], lop1[p], data_drv[p]));
            phase[p] = 0;
         end else if (rdy[p] && cmd_drv[p] != 4'd0) begin
            phase[p] = 1;
            lcmd[p]  = cmd_drv[p];
            lop1[p]  = data_drv[p];
            issued++;
         end
      end
      en = 1'b1;
   endtask

   task automatic check(string tag, int p, logic [63:0] got, logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s port %0d: got 0x%0h expected 0x%0h", tag, p, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge c_clk);
      #1;
      model_step();
      for (int p = 0; p < N; p++) begin
         check("ready", p, 64'(req_ready[p]), 64'(model_ready(p)));
         check("resp",  p, 64'(out_resp[p*2 +: 2]), 64'(exp_resp[p]));
         check("data",  p, 64'(out_data[p*W +: W]), 64'(exp_data[p]));
         if (out_resp[p*2 +: 2] != 2'd0) seen_resp++;
      end
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_resp"},  0, 64'(out_resp), 64'd0);
      check({tag, "_data"},  0, 64'(|out_data), 64'd0);
      check({tag, "_ready"}, 0, 64'(req_ready), 64'd0);
   endtask

   task automatic issue(int p, logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
      cmd_drv[p]  = c;
      data_drv[p] = a;
      tick();
      cmd_drv[p]  = 4'hF;   // must be ignored during the op2 cycle
      data_drv[p] = b;
      tick();
      cmd_drv[p]  = 4'd0;
      data_drv[p] = '0;
   endtask

   // Single request on an idle bench; result is due two cycles after op2.
   task automatic run_one(int p, logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b,
                          logic [1:0] er, logic [W-1:0] ed);
      issue(p, c, a, b);
      tick();
      check("direct_resp", p, 64'(out_resp[p*2 +: 2]), 64'(er));
      check("direct_data", p, 64'(out_data[p*W +: W]), 64'(ed));
      tick();
      check("pulse_clear", p, 64'(out_resp[p*2 +: 2]), 64'd0);
   endtask

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 3))
         0:       return W'($urandom_range(0, 40));
         1:       return 32'hFFFF_FFF0 + W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   function automatic logic [3:0] pick_cmd();
      logic [3:0] cmds [8];
      cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd15};
      return cmds[$urandom_range(0, 7)];
   endfunction

   initial begin
      n_assert = 0; n_fail = 0; issued = 0; seen_resp = 0;
      for (int p = 0; p < N; p++) begin
         cmd_drv[p]  = '0;
         data_drv[p] = '0;
      end
      model_reset();

      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("rst");
      @(posedge c_clk);
      @(posedge c_clk);
      #1 reset = 1'b1;
      check("ready_before_edge", 0, 64'(req_ready), 64'd0);
      tick();
      check("ready_after_edge", 0, 64'(req_ready), 64'hF);

      run_one(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000);
      run_one(1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
      run_one(1, 4'd2, 32'd5, 32'd7, 2'd2, 32'h0);
      run_one(1, 4'd2, 32'd7, 32'd5, 2'd1, 32'd2);
      run_one(2, 4'd5, 32'd1, 32'd35, 2'd1, 32'd8);
      run_one(2, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1);
      run_one(2, 4'd3, 32'd9, 32'd9, 2'd3, 32'h0);
      run_one(3, 4'd1, 32'd0, 32'd0, 2'd1, 32'd0);

      // After the port 3 grant, rotation restarts at port 0.
      for (int p = 0; p < N; p++) begin cmd_drv[p] = 4'd1; data_drv[p] = 32'd1; end
      tick();
      for (int p = 0; p < N; p++) begin cmd_drv[p] = 4'd0; data_drv[p] = 32'd1; end
      tick();
      for (int j = 0; j < N; j++) begin
         tick();
         check("rr_resp", j, 64'(out_resp[j*2 +: 2]), 64'd1);
         check("rr_data", j, 64'(out_data[j*W +: W]), 64'd2);
      end
      tick();

      // Back-to-back random traffic on all ports, then drain.
      for (int c = 0; c < 40; c++) begin
         for (int p = 0; p < N; p++) begin
            if (phase[p] == 1) begin
               cmd_drv[p]  = 4'($urandom);
               data_drv[p] = rand_op();
            end else if (model_ready(p) && $urandom_range(0, 3) != 0) begin
               cmd_drv[p]  = pick_cmd();
               data_drv[p] = rand_op();
            end else begin
               cmd_drv[p]  = 4'd0;
               data_drv[p] = W'($urandom);
            end
         end
         tick();
      end
      for (int c = 0; c < 30; c++) begin
         for (int p = 0; p < N; p++) begin
            cmd_drv[p]  = 4'd0;
            data_drv[p] = rand_op();
         end
         tick();
      end
      check("resp_count", 0, 64'(seen_resp), 64'(issued));

      // Queue work on every port, then reset in the middle of a cycle.
      for (int r = 0; r < 3; r++) begin
         for (int p = 0; p < N; p++) begin cmd_drv[p] = 4'd1; data_drv[p] = W'(r + 1); end
         tick();
         for (int p = 0; p < N; p++) begin cmd_drv[p] = 4'd0; data_drv[p] = 32'd10; end
         tick();
      end
      for (int p = 0; p < N; p++) begin cmd_drv[p] = 4'd2; data_drv[p] = 32'd50; end
      tick();
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      model_reset();
      for (int p = 0; p < N; p++) begin cmd_drv[p] = 4'd0; data_drv[p] = '0; end
      @(posedge c_clk);
      @(posedge c_clk);
      #1 reset = 1'b1;
      repeat (6) tick();
      run_one(0, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
